// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter.
//   - ALU opcode constants understood by the external ALU
//   - is_legal_op(): opcode legality check
//   - state_t: arbiter FSM states
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'h0;
   localparam logic [3:0] ALU_OR    = 4'h1;
   localparam logic [3:0] ALU_ADD   = 4'h2;
   localparam logic [3:0] ALU_SUB   = 4'h6;
   localparam logic [3:0] ALU_PASSB = 4'h7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] ctrl);
      return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
             (ctrl == ALU_SUB) || (ctrl == ALU_PASSB);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   req[1:0]    request lines (already masked by the caller when busy)
//   advance     a grant was accepted this cycle; move the pointer
//   gnt[1:0]    one-hot (or zero) grant, combinational from req and pointer
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // ptr_q = requester that wins a tie
   logic ptr_q;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // The pointer moves to the requester that lost (or was absent) on every accepted grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
         ptr_q <= 1'b0;
      end else if (advance) begin
         ptr_q <= gnt[0];
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// One operation in flight: IDLE (grant/accept) -> EXEC (drive ALU) -> RESP (hold result).
// Ports:
//   CLK, Reset_L                 clock / asynchronous active-low reset
//   ReqN{Valid,Ready,A,B,Ctrl}   operation request handshake, requester N
//   RspN{Valid,Ready,W,Zero,Err} registered response handshake, requester N
//   Alu{BusA,BusB,Ctrl}          operands/opcode to the ALU, held outside EXEC
//   Alu{BusW,Zero}               result from the ALU, captured at the end of EXEC
module alu_arbiter #(
   parameter int WIDTH = 64,
   parameter int CTRLW = 4
) (
   input  logic             CLK,
   input  logic             Reset_L,
   input  logic             Req0Valid,
   output logic             Req0Ready,
   input  logic [WIDTH-1:0] Req0A,
   input  logic [WIDTH-1:0] Req0B,
   input  logic [CTRLW-1:0] Req0Ctrl,
   output logic             Rsp0Valid,
   input  logic             Rsp0Ready,
   output logic [WIDTH-1:0] Rsp0W,
   output logic             Rsp0Zero,
   output logic             Rsp0Err,
   input  logic             Req1Valid,
   output logic             Req1Ready,
   input  logic [WIDTH-1:0] Req1A,
   input  logic [WIDTH-1:0] Req1B,
   input  logic [CTRLW-1:0] Req1Ctrl,
   output logic             Rsp1Valid,
   input  logic             Rsp1Ready,
   output logic [WIDTH-1:0] Rsp1W,
   output logic             Rsp1Zero,
   output logic             Rsp1Err,
   output logic [WIDTH-1:0] AluBusA,
   output logic [WIDTH-1:0] AluBusB,
   output logic [CTRLW-1:0] AluCtrl,
   input  logic [WIDTH-1:0] AluBusW,
   input  logic             AluZero
);

   import alu_pkg::*;

   state_t state_q, state_d;

   logic [1:0]       arb_req;
   logic [1:0]       gnt;
   logic             accept;
   logic             capture;
   logic             drain;

   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [CTRLW-1:0] sel_ctrl;
   logic             sel_legal;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CTRLW-1:0] ctrl_q;
   logic             illegal_q;
   logic             id_q;

   logic [1:0]       rsp_valid_q;
   logic [WIDTH-1:0] rsp_w_q [2];
   logic [1:0]       rsp_zero_q;
   logic [1:0]       rsp_err_q;

   // Requests are only presented to the arbiter in IDLE, so grants (and the pointer) are frozen while busy.
   assign arb_req = {Req1Valid, Req0Valid} & {2{state_q == IDLE}};

   rr_arb2 u_rr_arb2 (
      .clk     (CLK),
      .rst_n   (Reset_L),
      .req     (arb_req),
      .advance (accept),
      .gnt     (gnt)
   );

   assign sel_a     = gnt[1] ? Req1A    : Req0A;
   assign sel_b     = gnt[1] ? Req1B    : Req0B;
   assign sel_ctrl  = gnt[1] ? Req1Ctrl : Req0Ctrl;
   assign sel_legal = is_legal_op(4'(sel_ctrl));

   // State register
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (drain) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: handshakes and datapath strobes
   always_comb begin
      Req0Ready = 1'b0;
      Req1Ready = 1'b0;
      capture   = 1'b0;
      drain     = 1'b0;
      case (state_q)
         IDLE: begin
            // A grant implies the matching valid, so ready alone marks the handshake.
            Req0Ready = gnt[0];
            Req1Ready = gnt[1];
         end
         EXEC: capture = 1'b1;
         RESP: drain   = rsp_valid_q[id_q] & (id_q ? Rsp1Ready : Rsp0Ready);
         default: ;
      endcase
   end

   assign accept = Req0Ready | Req1Ready;

   // Operand registers double as the ALU drive: they only change on accept,
   // so the ALU inputs are stable through EXEC and hold their value elsewhere.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         a_q       <= '0;
         b_q       <= '0;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
         id_q      <= 1'b0;
      end else if (accept) begin
         a_q       <= sel_a;
         b_q       <= sel_b;
         ctrl_q    <= sel_legal ? sel_ctrl : '0;
         illegal_q <= ~sel_legal;
         id_q      <= gnt[1];
      end
   end

   assign AluBusA = a_q;
   assign AluBusB = b_q;
   assign AluCtrl = ctrl_q;

   // Response registers: loaded at the end of EXEC, valid cleared on the response handshake.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         rsp_valid_q <= 2'b00;
         rsp_zero_q  <= 2'b00;
         rsp_err_q   <= 2'b00;
         for (int i = 0; i < 2; i++) rsp_w_q[i] <= '0;
      end else begin
         if (capture) begin
            rsp_valid_q[id_q] <= 1'b1;
            rsp_w_q[id_q]     <= illegal_q ? '0 : AluBusW;
            rsp_zero_q[id_q]  <= illegal_q ? 1'b0 : AluZero;
            rsp_err_q[id_q]   <= illegal_q;
         end
         if (drain) rsp_valid_q[id_q] <= 1'b0;
      end
   end

   assign Rsp0Valid = rsp_valid_q[0];
   assign Rsp0W     = rsp_w_q[0];
   assign Rsp0Zero  = rsp_zero_q[0];
   assign Rsp0Err   = rsp_err_q[0];
   assign Rsp1Valid = rsp_valid_q[1];
   assign Rsp1W     = rsp_w_q[1];
   assign Rsp1Zero  = rsp_zero_q[1];
   assign Rsp1Err   = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A small behavioural ALU stands in for
// the external ALU instance. Inputs change just after the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
module tb_alu_arbiter;

   localparam int WIDTH = 64;
   localparam int CTRLW = 4;

   logic             CLK = 1'b0;
   logic             Reset_L;
   logic             Req0Valid, Req0Ready, Rsp0Valid, Rsp0Ready, Rsp0Zero, Rsp0Err;
   logic             Req1Valid, Req1Ready, Rsp1Valid, Rsp1Ready, Rsp1Zero, Rsp1Err;
   logic [WIDTH-1:0] Req0A, Req0B, Req1A, Req1B, Rsp0W, Rsp1W;
   logic [CTRLW-1:0] Req0Ctrl, Req1Ctrl, AluCtrl;
   logic [WIDTH-1:0] AluBusA, AluBusB, AluBusW;
   logic             AluZero;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   alu_arbiter #(.WIDTH(WIDTH), .CTRLW(CTRLW)) dut (
      .CLK       (CLK),
      .Reset_L   (Reset_L),
      .Req0Valid (Req0Valid),
      .Req0Ready (Req0Ready),
      .Req0A     (Req0A),
      .Req0B     (Req0B),
      .Req0Ctrl  (Req0Ctrl),
      .Rsp0Valid (Rsp0Valid),
      .Rsp0Ready (Rsp0Ready),
      .Rsp0W     (Rsp0W),
      .Rsp0Zero  (Rsp0Zero),
      .Rsp0Err   (Rsp0Err),
      .Req1Valid (Req1Valid),
      .Req1Ready (Req1Ready),
      .Req1A     (Req1A),
      .Req1B     (Req1B),
      .Req1Ctrl  (Req1Ctrl),
      .Rsp1Valid (Rsp1Valid),
      .Rsp1Ready (Rsp1Ready),
      .Rsp1W     (Rsp1W),
      .Rsp1Zero  (Rsp1Zero),
      .Rsp1Err   (Rsp1Err),
      .AluBusA   (AluBusA),
      .AluBusB   (AluBusB),
      .AluCtrl   (AluCtrl),
      .AluBusW   (AluBusW),
      .AluZero   (AluZero)
   );

   // Behavioural stand-in for the external ALU.
   always_comb begin
      AluBusW = '0;
      case (AluCtrl)
         4'h0: AluBusW = AluBusA & AluBusB;
         4'h1: AluBusW = AluBusA | AluBusB;
         4'h2: AluBusW = AluBusA + AluBusB;
         4'h6: AluBusW = AluBusA - AluBusB;
         4'h7: AluBusW = AluBusB;
         default: AluBusW = '0;
      endcase
      AluZero = (AluBusW == '0);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   initial begin
      Reset_L   = 1'b0;
      Req0Valid = 1'b0; Req0A = '0; Req0B = '0; Req0Ctrl = '0; Rsp0Ready = 1'b0;
      Req1Valid = 1'b0; Req1A = '0; Req1B = '0; Req1Ctrl = '0; Rsp1Ready = 1'b0;
      step(); step();
      #1;
      check("rst_rsp0_valid", 64'(Rsp0Valid), 64'd0);
      check("rst_rsp1_valid", 64'(Rsp1Valid), 64'd0);
      check("rst_rsp0_w",     Rsp0W,          64'd0);
      check("rst_alu_a",      AluBusA,        64'd0);
      check("rst_alu_ctrl",   64'(AluCtrl),   64'd0);
      check("rst_req0_ready", 64'(Req0Ready), 64'd0);
      Reset_L = 1'b1;
      step();

      // Single ADD from requester 0
      Req0Valid = 1'b1; Req0A = 64'hACEB; Req0B = 64'hABDDE000; Req0Ctrl = 4'h2; Rsp0Ready = 1'b1;
      #1;
      check("add_req0_ready", 64'(Req0Ready), 64'd1);
      check("add_req1_ready", 64'(Req1Ready), 64'd0);
      step();
      Req0Valid = 1'b0;
      #1;
      check("add_exec_ready", 64'(Req0Ready), 64'd0);
      check("add_exec_a",     AluBusA,        64'hACEB);
      check("add_exec_b",     AluBusB,        64'hABDDE000);
      check("add_exec_ctrl",  64'(AluCtrl),   64'd2);
      check("add_exec_valid", 64'(Rsp0Valid), 64'd0);
      step(); #1;
      check("add_rsp_valid",  64'(Rsp0Valid), 64'd1);
      check("add_rsp_w",      Rsp0W,          64'hABDE8CEB);
      check("add_rsp_zero",   64'(Rsp0Zero),  64'd0);
      check("add_rsp_err",    64'(Rsp0Err),   64'd0);
      check("add_rsp1_valid", 64'(Rsp1Valid), 64'd0);
      step(); #1;
      check("add_drained",    64'(Rsp0Valid), 64'd0);

      // Reset so the pointer is back at requester 0, then contend
      Reset_L = 1'b0; step(); Reset_L = 1'b1; step();
      Req0Valid = 1'b1; Req0A = 64'h98760000; Req0B = 64'h0;    Req0Ctrl = 4'h0;
      Req1Valid = 1'b1; Req1A = 64'h0;        Req1B = 64'h12ED; Req1Ctrl = 4'h6;
      Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;
      #1;
      check("rr1_req0_ready", 64'(Req0Ready), 64'd1);
      check("rr1_req1_ready", 64'(Req1Ready), 64'd0);
      step(); step(); #1;
      check("rr1_rsp0_valid", 64'(Rsp0Valid), 64'd1);
      check("rr1_rsp0_w",     Rsp0W,          64'd0);
      check("rr1_rsp0_zero",  64'(Rsp0Zero),  64'd1);
      check("rr1_rsp1_valid", 64'(Rsp1Valid), 64'd0);
      step(); #1;
      check("rr2_req1_ready", 64'(Req1Ready), 64'd1);
      check("rr2_req0_ready", 64'(Req0Ready), 64'd0);
      step(); step(); #1;
      check("rr2_rsp1_valid", 64'(Rsp1Valid), 64'd1);
      check("rr2_rsp1_w",     Rsp1W,          64'hFFFFFFFFFFFFED13);
      check("rr2_rsp1_zero",  64'(Rsp1Zero),  64'd0);
      check("rr2_rsp1_err",   64'(Rsp1Err),   64'd0);
      step(); #1;
      check("rr3_req0_ready", 64'(Req0Ready), 64'd1);
      check("rr3_req1_ready", 64'(Req1Ready), 64'd0);
      Req0Valid = 1'b0; Req1Valid = 1'b0;
      step();

      // Backpressure on requester 1 while requester 0 waits
      Req1Valid = 1'b1; Req1A = 64'h10101010; Req1B = 64'h01010101; Req1Ctrl = 4'h1; Rsp1Ready = 1'b0;
      #1;
      check("bp_req1_ready", 64'(Req1Ready), 64'd1);
      step();
      Req1Valid = 1'b0;
      Req0Valid = 1'b1; Req0A = 64'd1; Req0B = 64'd1; Req0Ctrl = 4'h2;
      #1;
      check("bp_exec_req0_ready", 64'(Req0Ready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         step(); #1;
         check("bp_rsp1_valid",   64'(Rsp1Valid), 64'd1);
         check("bp_rsp1_w",       Rsp1W,          64'h11111111);
         check("bp_req0_ready",   64'(Req0Ready), 64'd0);
      end
      Rsp1Ready = 1'b1;
      step(); #1;
      check("bp_rsp1_cleared",  64'(Rsp1Valid), 64'd0);
      check("bp_req0_ready_now", 64'(Req0Ready), 64'd1);
      Req0Valid = 1'b0;  // withdrawn before acceptance
      step(); step(); #1;
      check("bp_withdraw_rsp0", 64'(Rsp0Valid), 64'd0);
      check("bp_alu_a_held",    AluBusA,        64'h10101010);

      // Illegal opcode, then PASSB
      Req0Valid = 1'b1; Req0A = 64'hFF; Req0B = 64'hF0; Req0Ctrl = 4'h3; Rsp0Ready = 1'b0;
      #1;
      check("ill_req0_ready", 64'(Req0Ready), 64'd1);
      step();
      Req0Valid = 1'b0;
      #1;
      check("ill_exec_ctrl", 64'(AluCtrl), 64'd0);
      step(); #1;
      check("ill_rsp_valid", 64'(Rsp0Valid), 64'd1);
      check("ill_rsp_err",   64'(Rsp0Err),   64'd1);
      check("ill_rsp_w",     Rsp0W,          64'd0);
      check("ill_rsp_zero",  64'(Rsp0Zero),  64'd0);
      Rsp0Ready = 1'b1;
      step();
      Req0Valid = 1'b1; Req0A = 64'h1101BDE; Req0B = 64'h0; Req0Ctrl = 4'h7;
      #1;
      check("pb_req0_ready", 64'(Req0Ready), 64'd1);
      step();
      Req0Valid = 1'b0;
      #1;
      check("pb_exec_ctrl", 64'(AluCtrl), 64'd7);
      step(); #1;
      check("pb_rsp_valid", 64'(Rsp0Valid), 64'd1);
      check("pb_rsp_w",     Rsp0W,          64'd0);
      check("pb_rsp_zero",  64'(Rsp0Zero),  64'd1);
      check("pb_rsp_err",   64'(Rsp0Err),   64'd0);
      step();

      // Asynchronous reset during EXEC
      Req0Valid = 1'b1; Req0A = 64'd5; Req0B = 64'd6; Req0Ctrl = 4'h2;
      #1;
      check("mid_req0_ready", 64'(Req0Ready), 64'd1);
      step();
      Req0Valid = 1'b0;
      #2;
      Reset_L = 1'b0;
      #1;
      check("mid_alu_a",      AluBusA,        64'd0);
      check("mid_alu_ctrl",   64'(AluCtrl),   64'd0);
      check("mid_rsp1_w",     Rsp1W,          64'd0);
      check("mid_rsp0_zero",  64'(Rsp0Zero),  64'd0);
      check("mid_rsp0_valid", 64'(Rsp0Valid), 64'd0);
      step();
      Reset_L = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         check("mid_no_rsp0", 64'(Rsp0Valid), 64'd0);
      end
      Req1Valid = 1'b1; Req1A = 64'h0; Req1B = 64'h42; Req1Ctrl = 4'h7; Rsp1Ready = 1'b1;
      #1;
      check("mid_req1_ready", 64'(Req1Ready), 64'd1);
      step();
      Req1Valid = 1'b0;
      step(); #1;
      check("mid_rsp1_valid", 64'(Rsp1Valid), 64'd1);
      check("mid_rsp1_w2",    Rsp1W,          64'h42);
      step(); #1;
      check("mid_rsp1_drain", 64'(Rsp1Valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
